// File: rtl/udp_rx_pkt_buf.sv
// -----------------------------------------------------------------------------
// udp_rx_pkt_buf
//
// Ping-pong payload buffer behind the UDP receive parser. Each accepted payload
// is captured into one of two banks. Its length, and optionally its 16-bit-word
// sum, are checked. The frame is then replayed over a valid/ready byte stream.
// Frames that arrive while both banks are occupied are dropped and counted.
//
// Optional feature macro:
//   UDP_RX_PKT_BUF_SUM_CHK_EN - build the local payload sum. A mismatch against
//                               data_sum then sets the frame error flag.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   rx_done          parser accepted a frame (pulse, precedes the rx_en burst)
//   rx_en, rx_data   payload byte stream (contiguous burst)
//   word_cnt         expected payload length, sampled with rx_done
//   data_sum         parser payload sum, sampled when rx_en falls
//   m_valid/m_ready  output handshake
//   m_data, m_last   output byte and final-byte marker
//   m_len            frame length (held for the whole frame)
//   m_err            frame error, qualified by m_last
//   drop_cnt         saturating count of dropped frames
//   bank_full        per-bank occupied flags
// -----------------------------------------------------------------------------
module udp_rx_pkt_buf #(
    parameter int BANK_DEPTH = 2048,
    parameter int LEN_W      = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_done,
    input  logic             rx_en,
    input  logic [7:0]       rx_data,
    input  logic [LEN_W-1:0] word_cnt,
    input  logic [31:0]      data_sum,
    output logic             m_valid,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic [LEN_W-1:0] m_len,
    output logic             m_err,
    input  logic             m_ready,
    output logic [15:0]      drop_cnt,
    output logic [1:0]       bank_full
);
    localparam int BANK_AW = $clog2(BANK_DEPTH);
    localparam int MEM_AW  = BANK_AW + 1;

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_STREAM} rd_state_t;

    // Both banks share one array; the bank select is the address MSB.
    logic [7:0] mem [0:2*BANK_DEPTH-1];

    // ---------------- write side state ----------------
    wr_state_t               wr_state_q;
    logic                    wr_sel_q;
    logic [LEN_W-1:0]        wr_addr_q;
    logic [LEN_W-1:0]        exp_len_q;
    logic                    seen_q;     // at least one rx_en cycle seen in this burst
    logic                    ovf_q;      // bytes arrived beyond exp_len
    logic [15:0]             drop_cnt_q;

    // ---------------- per-bank metadata ----------------
    logic [1:0][LEN_W-1:0]   len_q;      // expected length (presented on m_len)
    logic [1:0][LEN_W-1:0]   cnt_q;      // bytes actually stored (drives m_last)
    logic [1:0]              err_q;
    logic [1:0]              full_q;

    // ---------------- read side state ----------------
    rd_state_t               rd_state_q;
    logic                    rd_sel_q;
    logic [LEN_W-1:0]        idx_q;      // index of the byte sitting in rdata_q
    logic [7:0]              rdata_q;
    logic                    m_valid_q;
    logic [7:0]              m_data_q;
    logic                    m_last_q;
    logic                    m_err_q;
    logic [LEN_W-1:0]        m_len_q;

    logic                    wr_store;
    logic                    commit;
    logic                    commit_err;
    logic                    sum_mismatch;
    logic                    rd_release;
    logic                    rd_adv;
    logic                    rd_en;
    logic [LEN_W-1:0]        rd_idx;
    logic [LEN_W-1:0]        last_idx;
    logic [MEM_AW-1:0]       wr_mem_addr;
    logic [MEM_AW-1:0]       rd_mem_addr;

    assign wr_store    = (wr_state_q == W_FILL) && rx_en && (wr_addr_q < exp_len_q);
    assign commit      = (wr_state_q == W_FILL) && !rx_en && seen_q;
    assign commit_err  = (wr_addr_q != exp_len_q) || ovf_q || sum_mismatch;
    assign wr_mem_addr = {wr_sel_q, BANK_AW'(wr_addr_q)};

`ifdef UDP_RX_PKT_BUF_SUM_CHK_EN
    // Running sum of big-endian 16-bit words: even-index bytes land in the
    // high byte, odd-index bytes in the low byte. An odd tail byte therefore
    // behaves as if padded with a zero low byte.
    logic [31:0] sum_q;
    logic [31:0] sum_term;

    assign sum_term = wr_addr_q[0] ? {24'd0, rx_data} : {16'd0, rx_data, 8'd0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if ((wr_state_q == W_IDLE) && rx_done) begin
            sum_q <= '0;
        end else if (wr_store) begin
            sum_q <= sum_q + sum_term;
        end
    end

    assign sum_mismatch = (sum_q != data_sum);
`else
    logic unused_data_sum;
    assign unused_data_sum = ^data_sum;
    assign sum_mismatch    = 1'b0;
`endif

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            wr_sel_q   <= 1'b0;
            wr_addr_q  <= '0;
            exp_len_q  <= '0;
            seen_q     <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (rx_done && (word_cnt != '0)) begin
                        seen_q <= 1'b0;
                        if (full_q[wr_sel_q]) begin
                            wr_state_q <= W_DROP;
                            if (drop_cnt_q != 16'hFFFF) begin
                                drop_cnt_q <= drop_cnt_q + 16'd1;
                            end
                        end else begin
                            wr_state_q <= W_FILL;
                            exp_len_q  <= word_cnt;
                            wr_addr_q  <= '0;
                            ovf_q      <= 1'b0;
                        end
                    end
                end
                W_FILL: begin
                    if (rx_en) begin
                        seen_q <= 1'b1;
                        if (wr_store) begin
                            wr_addr_q <= wr_addr_q + LEN_W'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end else if (seen_q) begin
                        len_q[wr_sel_q] <= exp_len_q;
                        cnt_q[wr_sel_q] <= wr_addr_q;
                        err_q[wr_sel_q] <= commit_err;
                        wr_sel_q        <= ~wr_sel_q;
                        wr_state_q      <= W_IDLE;
                    end
                end
                W_DROP: begin
                    if (rx_en) begin
                        seen_q <= 1'b1;
                    end else if (seen_q) begin
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // Full flags are set by the writer and cleared by the reader. The two never
    // target the same bank in one cycle, because the writer only reaches a bank
    // once it is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
        end else begin
            if (commit) begin
                full_q[wr_sel_q] <= 1'b1;
            end
            if (rd_release) begin
                full_q[rd_sel_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_store) begin
            mem[wr_mem_addr] <= rx_data;
        end
    end

    // ---------------- read side ----------------
    // rdata_q prefetches the byte after the one presented. A new byte can
    // therefore move into the output register on every accepted handshake.
    assign rd_release  = (rd_state_q == R_STREAM) && m_valid_q && m_ready && m_last_q;
    assign rd_adv      = (rd_state_q == R_STREAM) && (!m_valid_q || m_ready) && !rd_release;
    assign rd_en       = (rd_state_q == R_LOAD) || rd_adv;
    assign rd_idx      = (rd_state_q == R_LOAD) ? '0 : idx_q + LEN_W'(1);
    assign rd_mem_addr = {rd_sel_q, BANK_AW'(rd_idx)};
    assign last_idx    = cnt_q[rd_sel_q] - LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata_q <= mem[rd_mem_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            rd_sel_q   <= 1'b0;
            idx_q      <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
            m_err_q    <= 1'b0;
            m_len_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (full_q[rd_sel_q]) begin
                        rd_state_q <= R_LOAD;
                    end
                end
                R_LOAD: begin
                    m_len_q    <= len_q[rd_sel_q];
                    idx_q      <= '0;
                    rd_state_q <= R_STREAM;
                end
                R_STREAM: begin
                    if (rd_release) begin
                        m_valid_q  <= 1'b0;
                        m_last_q   <= 1'b0;
                        m_err_q    <= 1'b0;
                        rd_sel_q   <= ~rd_sel_q;
                        rd_state_q <= R_IDLE;
                    end else if (rd_adv) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= rdata_q;
                        m_last_q  <= (idx_q == last_idx);
                        m_err_q   <= (idx_q == last_idx) && err_q[rd_sel_q];
                        idx_q     <= idx_q + LEN_W'(1);
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign m_err     = m_err_q;
    assign m_len     = m_len_q;
    assign drop_cnt  = drop_cnt_q;
    assign bank_full = full_q;

endmodule

// File: tb/tb_udp_rx_pkt_buf.sv
// -----------------------------------------------------------------------------
// tb_udp_rx_pkt_buf
//
// Scoreboard bench for udp_rx_pkt_buf. Every frame sent pushes its expected
// output bytes (data, last, err, len) into a queue. The output monitor pops
// one entry per handshake and compares it. Bytes held under back-pressure are
// also checked for stability.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_udp_rx_pkt_buf;
    localparam int LEN_W = 11;

    typedef struct packed {
        logic [7:0]       data;
        logic             last;
        logic             err;
        logic [LEN_W-1:0] len;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rx_done;
    logic             rx_en;
    logic [7:0]       rx_data;
    logic [LEN_W-1:0] word_cnt;
    logic [31:0]      data_sum;
    logic             m_valid;
    logic [7:0]       m_data;
    logic             m_last;
    logic [LEN_W-1:0] m_len;
    logic             m_err;
    logic             m_ready;
    logic [15:0]      drop_cnt;
    logic [1:0]       bank_full;

    udp_rx_pkt_buf #(.BANK_DEPTH(2048), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_done   (rx_done),
        .rx_en     (rx_en),
        .rx_data   (rx_data),
        .word_cnt  (word_cnt),
        .data_sum  (data_sum),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_len     (m_len),
        .m_err     (m_err),
        .m_ready   (m_ready),
        .drop_cnt  (drop_cnt),
        .bank_full (bank_full)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   hs_cnt   = 0;
    exp_t exp_q[$];
    logic [7:0] fb [0:15];
    logic stall_prev = 1'b0;
    exp_t hold;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    // Reference sum: big-endian 16-bit words, odd tail padded with zero.
    function automatic logic [31:0] model_sum(input int n);
        logic [31:0] s;
        logic [15:0] w;
        s = 32'd0;
        for (int i = 0; i < n; i += 2) begin
            w = {fb[i], (i + 1 < n) ? fb[i+1] : 8'h00};
            s = s + {16'd0, w};
        end
        return s;
    endfunction

    // Drives one frame (rx_done, then nb payload bytes). When store=1 the
    // expected replay is pushed to the scoreboard.
    task automatic send_frame(input int nb, input int wc, input logic [31:0] dsum, input bit store);
        int   ns;
        logic e;
        exp_t x;
        if (store) begin
            ns = (nb < wc) ? nb : wc;
            e  = (nb != wc);
`ifdef UDP_RX_PKT_BUF_SUM_CHK_EN
            e = e | (model_sum(ns) != dsum);
`endif
            for (int i = 0; i < ns; i++) begin
                x.data = fb[i];
                x.last = (i == ns - 1);
                x.err  = (i == ns - 1) && e;
                x.len  = LEN_W'(wc);
                exp_q.push_back(x);
            end
        end
        @(posedge clk); #1;
        data_sum = dsum;
        word_cnt = LEN_W'(wc);
        rx_done  = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        for (int i = 0; i < nb; i++) begin
            rx_en   = 1'b1;
            rx_data = fb[i];
            @(posedge clk); #1;
        end
        rx_en   = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
        check_eq(tag, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int k = 0; k < budget && !m_valid; k++) @(negedge clk);
        check_eq(tag, m_valid, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, m_valid, 0);
        check_eq({tag, "_data"}, m_data, 0);
        check_eq({tag, "_last"}, m_last, 0);
        check_eq({tag, "_len"}, m_len, 0);
        check_eq({tag, "_err"}, m_err, 0);
        check_eq({tag, "_drop"}, drop_cnt, 0);
        check_eq({tag, "_full"}, bank_full, 0);
    endtask

    // Output monitor: one line per accepted byte.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                check_eq("stall_valid", m_valid, 1'b1);
                check_eq("stall_data", m_data, hold.data);
                check_eq("stall_last", m_last, hold.last);
                check_eq("stall_err", m_err, hold.err);
                check_eq("stall_len", m_len, hold.len);
            end
            stall_prev <= m_valid && !m_ready;
            hold <= '{data: m_data, last: m_last, err: m_err, len: m_len};
            if (m_valid && m_ready) begin
                hs_cnt <= hs_cnt + 1;
                $display("[%0t] out byte=%02h last=%0d err=%0d len=%0d", $time, m_data, m_last, m_err, m_len);
                check_eq("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    check_eq("out_data", m_data, exp_q[0].data);
                    check_eq("out_last", m_last, exp_q[0].last);
                    check_eq("out_err", m_err, exp_q[0].err);
                    check_eq("out_len", m_len, exp_q[0].len);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int h0;
        rst_n    = 1'b0;
        rx_done  = 1'b0;
        rx_en    = 1'b0;
        rx_data  = 8'h00;
        word_cnt = '0;
        data_sum = 32'd0;
        m_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Single 6-byte frame, also measuring the first-valid latency.
        for (int i = 0; i < 6; i++) fb[i] = 8'(i + 1);
        send_frame(6, 6, 32'h0000090C, 1'b1);
        for (int k = 0; k < 20 && bank_full == 2'b00; k++) @(negedge clk);
        check_eq("commit_bank0", bank_full, 2'b01);
        n = 0;
        while (!m_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("first_valid_latency", n, 3);
        wait_drain("drain_single", 50);
        @(negedge clk);
        check_eq("release_single", bank_full, 2'b00);

        // Odd length, matching sum, then mismatching sum.
        fb[0] = 8'hAA; fb[1] = 8'hBB; fb[2] = 8'hCC;
        send_frame(3, 3, model_sum(3), 1'b1);
        wait_drain("drain_odd_ok", 50);
        send_frame(3, 3, 32'd0, 1'b1);
        wait_drain("drain_odd_bad", 50);

        // Short burst, then long burst.
        for (int i = 0; i < 10; i++) fb[i] = 8'(8'h40 + i);
        send_frame(5, 8, model_sum(5), 1'b1);
        wait_drain("drain_short", 50);
        send_frame(10, 4, model_sum(4), 1'b1);
        wait_drain("drain_long", 50);

        // Zero-length frame is ignored entirely.
        send_frame(0, 0, 32'd0, 1'b0);
        repeat (6) @(negedge clk);
        check_eq("zero_len_full", bank_full, 2'b00);
        check_eq("zero_len_drop", drop_cnt, 0);
        check_eq("zero_len_valid", m_valid, 1'b0);

        // Back-pressure: two frames fill both banks, third is dropped.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fb[i] = 8'(8'h10 + i);
        send_frame(4, 4, model_sum(4), 1'b1);
        for (int i = 0; i < 5; i++) fb[i] = 8'(8'h20 + i);
        send_frame(5, 5, model_sum(5), 1'b1);
        for (int i = 0; i < 3; i++) fb[i] = 8'(8'h30 + i);
        send_frame(3, 3, model_sum(3), 1'b0);
        repeat (3) @(negedge clk);
        check_eq("bp_bank_full", bank_full, 2'b11);
        check_eq("bp_drop_cnt", drop_cnt, 1);
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_drain("drain_bp", 100);
        @(negedge clk);
        check_eq("bp_release", bank_full, 2'b00);
        check_eq("bp_drop_hold", drop_cnt, 1);

        // m_ready toggling during a 4-byte frame.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fb[i] = 8'(8'hC0 + i);
        send_frame(4, 4, model_sum(4), 1'b1);
        wait_valid("toggle_valid", 20);
        @(posedge clk); #1;
        h0 = hs_cnt;
        for (int k = 0; k < 8; k++) begin
            m_ready = (k % 2 == 0);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("toggle_handshakes", hs_cnt - h0, 4);
        check_eq("toggle_sb_empty", exp_q.size(), 0);

        // Asynchronous reset in the middle of an output frame.
        for (int i = 0; i < 8; i++) fb[i] = 8'(8'h70 + i);
        send_frame(8, 8, model_sum(8), 1'b1);
        wait_valid("rst_mid_valid", 20);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) fb[i] = 8'(8'hE0 + i);
        send_frame(3, 3, model_sum(3), 1'b1);
        wait_drain("drain_after_rst", 50);
        @(negedge clk);
        check_eq("after_rst_full", bank_full, 2'b00);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
